// File: rtl/pattern_matcher_pkg.sv
// ============================================================================
// Module   : pattern_matcher_pkg
// Brief    : Shared defaults and elaboration-time helpers for pattern_matcher.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pattern_matcher_pkg;

  localparam int DEFAULT_PATTERN_LEN = 2;
  localparam logic [DEFAULT_PATTERN_LEN-1:0] DEFAULT_PATTERN = 2'b01;
  localparam int MAX_PATTERN_LEN = 16;

  function automatic int state_width(input int len);
    return $clog2(len + 1);
  endfunction

  // Longest prefix of pat that is a suffix of (first k pattern bits, bit_in).
  // States beyond len are unreachable and fall back to S0.
  function automatic int next_state_calc(input int len, input logic [MAX_PATTERN_LEN-1:0] pat,
                                         input int k, input logic bit_in);
    int   best;
    int   q;
    logic ok;
    logic c;
    best = 0;
    if (k > len) return 0;
    for (int j = 1; j <= MAX_PATTERN_LEN; j++) begin
      if (j <= len && j <= k + 1) begin
        ok = 1'b1;
        for (int p = 0; p < MAX_PATTERN_LEN; p++) begin
          if (p < j) begin
            q = k + 1 - j + p;
            c = (q == k) ? bit_in : pat[len-1-q];
            if (c != pat[len-1-p]) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pattern_matcher_next.sv
// ============================================================================
// Module   : pattern_matcher_next
// Brief    : Combinational next-state lookup built from the pattern at elaboration.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pattern_matcher_next
  import pattern_matcher_pkg::*;
#(
  parameter int                     PATTERN_LEN = DEFAULT_PATTERN_LEN,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = PATTERN_LEN'(DEFAULT_PATTERN),
  localparam int                    SW          = state_width(PATTERN_LEN)
) (
  input  logic [SW-1:0] state,
  input  logic          a,
  output logic [SW-1:0] next_state
);

  localparam int NS = 2 ** SW;

  logic [SW-1:0] w_tab0 [NS];
  logic [SW-1:0] w_tab1 [NS];

  // Full 2**SW table so any encoding, reachable or not, has a defined successor.
  for (genvar k = 0; k < NS; k++) begin : g_state
    assign w_tab0[k] = SW'(next_state_calc(PATTERN_LEN, MAX_PATTERN_LEN'(PATTERN), k, 1'b0));
    assign w_tab1[k] = SW'(next_state_calc(PATTERN_LEN, MAX_PATTERN_LEN'(PATTERN), k, 1'b1));
  end

  assign next_state = a ? w_tab1[state] : w_tab0[state];

endmodule

`default_nettype wire

// File: rtl/pattern_matcher.sv
// ============================================================================
// Module   : pattern_matcher
// Brief    : Moore serial pattern detector with overlapping-match support.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pattern_matcher
  import pattern_matcher_pkg::*;
#(
  parameter int                     PATTERN_LEN = DEFAULT_PATTERN_LEN,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = PATTERN_LEN'(DEFAULT_PATTERN)
) (
  input  logic CLK,
  input  logic reset,
  input  logic a,
  output logic b
);

  localparam int SW = state_width(PATTERN_LEN);
  localparam logic [SW-1:0] S0 = '0;
  localparam logic [SW-1:0] SN = SW'(PATTERN_LEN);

  logic [SW-1:0] r_state;
  logic [SW-1:0] w_next;

  pattern_matcher_next #(
    .PATTERN_LEN (PATTERN_LEN),
    .PATTERN     (PATTERN)
  ) u_next (
    .state      (r_state),
    .a          (a),
    .next_state (w_next)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) r_state <= S0;
    else       r_state <= w_next;
  end

  // Decode depends only on the state register, never on a.
  assign b = (r_state == SN);

endmodule

`default_nettype wire

// File: tb/tb_pattern_matcher.sv
// ============================================================================
// Module   : tb_pattern_matcher
// Brief    : Scoreboard bench for pattern_matcher (default 01 and 101 instances).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pattern_matcher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a   = 1'b0;
  logic b2;
  logic b3;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] hist = '0;
  int          cnt  = 0;
  logic        q2[$];
  logic        q3[$];
  logic        e2;
  logic        e3;

  always #5 clk = ~clk;

  pattern_matcher dut2 (.CLK(clk), .reset(rst), .a(a), .b(b2));

  pattern_matcher #(.PATTERN_LEN(3), .PATTERN(3'b101)) dut3 (.CLK(clk), .reset(rst), .a(a), .b(b3));

  // Reference model: compare the most recent sampled bits against each pattern.
  task automatic step(input logic v);
    a    = v;
    hist = {hist[30:0], v};
    cnt++;
    q2.push_back(cnt >= 2 && hist[1:0] == 2'b01);
    q3.push_back(cnt >= 3 && hist[2:0] == 3'b101);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    a   = 1'b0;
    #7;
    rst  = 1'b0;
    hist = '0;
    cnt  = 0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (b2 !== 1'b0) $display("FAIL reset_b2_early: got %0b want 0", b2); else n_pass++;
    n_checks++; if (b3 !== 1'b0) $display("FAIL reset_b3_early: got %0b want 0", b3); else n_pass++;
    #5;
    n_checks++; if (b2 !== 1'b0) $display("FAIL reset_b2_edge: got %0b want 0", b2); else n_pass++;
    n_checks++; if (dut2.r_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dut2.r_state); else n_pass++;
    #2;
    rst = 1'b0;
    step(1'b0);
    e2 = q2.pop_front(); e3 = q3.pop_front();
    n_checks++; if (b2 !== e2) $display("FAIL reset_first_edge_b2: got %0b want %0b", b2, e2); else n_pass++;
    n_checks++; if (b3 !== e3) $display("FAIL reset_first_edge_b3: got %0b want %0b", b3, e3); else n_pass++;
  endtask

  task automatic test_seq_0011();
    logic [3:0] stim = 4'b0011;
    logic [1:0] exp_st [4] = '{2'd1, 2'd1, 2'd2, 2'd0};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(stim[3-i]);
      e2 = q2.pop_front(); e3 = q3.pop_front();
      n_checks++; if (b2 !== e2) $display("FAIL s0011_b2[%0d]: got %0b want %0b", i, b2, e2); else n_pass++;
      n_checks++; if (b3 !== e3) $display("FAIL s0011_b3[%0d]: got %0b want %0b", i, b3, e3); else n_pass++;
      n_checks++;
      if (dut2.r_state !== exp_st[i]) $display("FAIL s0011_state[%0d]: got %0d want %0d", i, dut2.r_state, exp_st[i]);
      else n_pass++;
    end
  endtask

  task automatic test_overlap_0101();
    logic [3:0] stim = 4'b0101;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(stim[3-i]);
      e2 = q2.pop_front(); e3 = q3.pop_front();
      n_checks++; if (b2 !== e2) $display("FAIL s0101_b2[%0d]: got %0b want %0b", i, b2, e2); else n_pass++;
      n_checks++; if (b3 !== e3) $display("FAIL s0101_b3[%0d]: got %0b want %0b", i, b3, e3); else n_pass++;
    end
  endtask

  task automatic test_constant();
    for (int v = 1; v >= 0; v--) begin
      apply_reset();
      for (int i = 0; i < 5; i++) begin
        step(v[0]);
        e2 = q2.pop_front(); e3 = q3.pop_front();
        n_checks++; if (b2 !== e2) $display("FAIL const%0d_b2[%0d]: got %0b want %0b", v, i, b2, e2); else n_pass++;
        n_checks++; if (b3 !== e3) $display("FAIL const%0d_b3[%0d]: got %0b want %0b", v, i, b3, e3); else n_pass++;
      end
    end
    n_checks++; if (dut2.r_state !== 2'd1) $display("FAIL const0_state: got %0d want 1", dut2.r_state); else n_pass++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(1'b0);
    e2 = q2.pop_front(); e3 = q3.pop_front();
    step(1'b1);
    e2 = q2.pop_front(); e3 = q3.pop_front();
    n_checks++; if (b2 !== e2) $display("FAIL async_pre_b2: got %0b want %0b", b2, e2); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (b2 !== 1'b0) $display("FAIL async_b2: got %0b want 0", b2); else n_pass++;
    n_checks++; if (dut2.r_state !== 2'd0) $display("FAIL async_state: got %0d want 0", dut2.r_state); else n_pass++;
    rst  = 1'b0;
    hist = '0;
    cnt  = 0;
    step(1'b1);
    e2 = q2.pop_front(); e3 = q3.pop_front();
    n_checks++; if (b2 !== e2) $display("FAIL async_post_b2: got %0b want %0b", b2, e2); else n_pass++;
  endtask

  task automatic test_pattern101();
    logic [4:0] stim = 5'b10101;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(stim[4-i]);
      e2 = q2.pop_front(); e3 = q3.pop_front();
      n_checks++; if (b3 !== e3) $display("FAIL p101_b3[%0d]: got %0b want %0b", i, b3, e3); else n_pass++;
      n_checks++; if (b2 !== e2) $display("FAIL p101_b2[%0d]: got %0b want %0b", i, b2, e2); else n_pass++;
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)));
      e2 = q2.pop_front(); e3 = q3.pop_front();
      n_checks++; if (b2 !== e2) $display("FAIL rand_b2[%0d]: got %0b want %0b", i, b2, e2); else n_pass++;
      n_checks++; if (b3 !== e3) $display("FAIL rand_b3[%0d]: got %0b want %0b", i, b3, e3); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_seq_0011();
    test_overlap_0101();
    test_constant();
    test_async_reset();
    test_pattern101();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/pattern_matcher.md
PATTERN_MATCHER -- requirements
Module: pattern_matcher

Interface
REQ-001 The block SHALL have parameter PATTERN_LEN, default 2, giving the number of bits in the target pattern (legal range 1..16).
REQ-002 The block SHALL have parameter PATTERN, default 2'b01, giving the target sequence; the MSB is the oldest bit expected on a.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port a, input, 1 bit: the serial data bit, sampled on each rising CLK edge.
REQ-006 The block SHALL have port b, output, 1 bit: the match flag.

Function
REQ-007 The block SHALL be a Moore FSM; b SHALL be a function of the current state only, driven from a register with no combinational path from a to b.
REQ-008 The FSM SHALL have PATTERN_LEN+1 states, S0..SN with N=PATTERN_LEN; Sk means the longest suffix of the sampled input equal to a prefix of PATTERN has length k.
REQ-009 From Sk with k<N, sampling a bit equal to pattern bit k+1 SHALL move the FSM to Sk+1.
REQ-010 Otherwise, the next state SHALL be Sj, where j is the length of the longest proper prefix of PATTERN that is a suffix of (matched prefix followed by the sampled bit), i.e. KMP failure rule.
REQ-011 From SN, the next state SHALL be computed by the same longest-suffix rule, so that overlapping matches are detected.
REQ-012 b SHALL be 1 exactly while the FSM is in SN, and 0 in every other state.
REQ-013 Latency: b SHALL rise in the cycle following the rising edge that samples the last pattern bit, and SHALL stay high one cycle unless the next sampled bit completes another overlapping match.
REQ-014 With the default pattern 01, the FSM SHALL behave as follows:
- S0 --a=0--> S1; S0 --a=1--> S0.
- S1 --a=0--> S1; S1 --a=1--> S2.
- S2 --a=0--> S1; S2 --a=1--> S0.
REQ-015 If a stays constant across several edges, each edge SHALL be treated as a separate sampled bit.
REQ-016 Transition tables SHALL be derived from the parameters at elaboration time; there SHALL be no runtime pattern loading.

Reset
REQ-017 While reset=1, the FSM SHALL be held in S0 and b SHALL be 0, independent of CLK and a.
REQ-018 Assertion of reset SHALL take effect immediately, not at the next clock edge, including mid-match; any partial match SHALL be discarded.
REQ-019 On the first rising edge after reset deasserts, a SHALL be sampled from S0.

Structure
REQ-020 A shared package pattern_matcher_pkg SHALL hold:
- the default PATTERN_LEN and PATTERN constants;
- the state-index width function (clog2(PATTERN_LEN+1));
- a constant function computing the next-state (failure) table.
REQ-021 One sub-module, pattern_matcher_next, SHALL be used: purely combinational, mapping (state, a) to the next state.
REQ-022 The top level SHALL contain only the state register and the output decode.

Verification
REQ-023 Hold reset=1 with a=0 for 10 ns, then release -> b=0 throughout reset and on the first edge after release.
REQ-024 Default pattern, apply a = 0,0,1,1 on successive edges -> state sequence S1,S1,S2,S0, and b=1 for exactly one cycle after the first 1 is sampled.
REQ-025 Default pattern, apply a = 0,1,0,1 -> b pulses twice, each pulse one cycle wide, in the cycles after the 2nd and 4th edges.
REQ-026 Default pattern, hold a=1 for 5 edges from reset -> b stays 0; hold a=0 for 5 edges -> b stays 0, state S1.
REQ-027 Assert reset asynchronously mid-cycle while in S2 -> b drops to 0 before the next CLK edge, and the state is S0.
REQ-028 Set PATTERN_LEN=3, PATTERN=3'b101, apply a = 1,0,1,0,1 -> b pulses after the 3rd and 5th edges (overlapping match).
